// File: rtl/mul_pkg.sv
// mul_pkg: shared op/state types and wrap-around sequence-number compare for the execute cluster
package mul_pkg;
    typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
    function automatic logic sqn_older_eq(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
        logic [31:0] d;
        // move the w-bit difference to the top so its sign bit becomes the word sign
        d = (a - b) << (32 - w);
        return $signed(d) <= 0;
    endfunction
endpackage

// File: rtl/mul_if.sv
// mul_if: issue, flush and writeback handshake of the iterative multiplier
interface mul_if #(
    parameter int XLEN = 32,
    parameter int TAG_W = 7,
    parameter int NM_W = 5,
    parameter int SQN_W = 6
);
    import mul_pkg::*;
    logic valid;
    mul_op_t op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [TAG_W-1:0] tag_dst;
    logic [NM_W-1:0] nm_dst;
    logic [SQN_W-1:0] sqn;
    logic flush;
    logic [SQN_W-1:0] flush_sqn;
    logic busy;
    logic res_valid;
    logic res_ready;
    logic [XLEN-1:0] result;
    logic [TAG_W-1:0] res_tag_dst;
    logic [NM_W-1:0] res_nm_dst;
    logic [SQN_W-1:0] res_sqn;
    modport master(output valid, op, src_a, src_b, tag_dst, nm_dst, sqn, flush, flush_sqn, res_ready,
                   input busy, res_valid, result, res_tag_dst, res_nm_dst, res_sqn);
    modport slave(input valid, op, src_a, src_b, tag_dst, nm_dst, sqn, flush, flush_sqn, res_ready,
                  output busy, res_valid, result, res_tag_dst, res_nm_dst, res_sqn);
endinterface

// File: rtl/mul_step.sv
// mul_step: one radix-2^BITS partial-product accumulate into the double-width sum
module mul_step #(
    parameter int XLEN = 32,
    parameter int BITS = 4,
    parameter int SW = 4
) (
    input logic [2*XLEN-1:0] acc,
    input logic [XLEN-1:0] ma,
    input logic [BITS-1:0] digit,
    input logic [SW-1:0] step,
    output logic [2*XLEN-1:0] acc_next
);
    logic [XLEN+BITS-1:0] pp;
    assign pp = {{BITS{1'b0}}, ma} * {{XLEN{1'b0}}, digit};
    assign acc_next = acc + ((2*XLEN)'(pp) << (BITS * step));
endmodule

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative sign-magnitude multiplier (MUL/MULH/MULHSU/MULHU) with early exit,
// writeback backpressure and branch-flush kill
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BITS = 4,
    parameter int EARLY_TERM = 1,
    parameter int TAG_W = 7,
    parameter int NM_W = 5,
    parameter int SQN_W = 6
) (
    input logic clk,
    input logic rst,
    mul_if.slave bus
);
    localparam int N = XLEN / BITS;
    localparam int SW = $clog2(N) + 1;
    mul_state_t state, state_nxt;
    mul_op_t op;
    logic [XLEN-1:0] ma, mb, mb_nxt;
    logic [2*XLEN-1:0] acc, acc_nxt, r;
    logic [SW-1:0] step;
    logic [TAG_W-1:0] tag_dst;
    logic [NM_W-1:0] nm_dst;
    logic [SQN_W-1:0] sqn;
    logic neg, sa, sb, kill_in, kill_cur, accept, last;
    assign kill_in = bus.flush && !sqn_older_eq(32'(bus.sqn), 32'(bus.flush_sqn), SQN_W);
    assign kill_cur = bus.flush && !sqn_older_eq(32'(sqn), 32'(bus.flush_sqn), SQN_W);
    assign sa = bus.op != MULHU && bus.src_a[XLEN-1];
    assign sb = (bus.op == MUL || bus.op == MULH) && bus.src_b[XLEN-1];
    assign accept = state == IDLE && bus.valid && !kill_in;
    assign mb_nxt = mb >> BITS;
    assign last = step == SW'(N - 1) || (EARLY_TERM != 0 && mb_nxt == '0);
    assign r = neg ? -acc_nxt : acc_nxt;
    assign bus.busy = state != IDLE;
    mul_step #(.XLEN(XLEN), .BITS(BITS), .SW(SW)) u_step (
        .acc(acc), .ma(ma), .digit(mb[BITS-1:0]), .step(step), .acc_next(acc_nxt)
    );
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (accept ? RUN : IDLE) :
                    kill_cur ? IDLE :
                    state == RUN ? (last ? DONE : RUN) :
                    (bus.res_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.res_valid <= 1'b0;
            bus.result <= '0;
            bus.res_tag_dst <= '0;
            bus.res_nm_dst <= '0;
            bus.res_sqn <= '0;
        end else begin
            state <= state_nxt;
            bus.res_valid <= state_nxt == DONE;
            if (accept) begin
                ma <= sa ? -bus.src_a : bus.src_a;
                mb <= sb ? -bus.src_b : bus.src_b;
                acc <= '0;
                step <= '0;
                neg <= sa ^ sb;
                op <= bus.op;
                tag_dst <= bus.tag_dst;
                nm_dst <= bus.nm_dst;
                sqn <= bus.sqn;
            end
            if (state == RUN) begin
                acc <= acc_nxt;
                mb <= mb_nxt;
                step <= step + 1'b1;
            end
            if (state == RUN && state_nxt == DONE) begin
                bus.result <= op == MUL ? r[XLEN-1:0] : r[2*XLEN-1:XLEN];
                bus.res_tag_dst <= tag_dst;
                bus.res_nm_dst <= nm_dst;
                bus.res_sqn <= sqn;
            end
        end
    end
    assert property (@(posedge clk) disable iff (rst) !(bus.valid && bus.busy));
endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: three configurations (32/4 full, 32/4 early-exit, 64/8 full) share one stimulus stream
module tb_mul_iter_unit;
    import mul_pkg::*;
    typedef struct {
        logic [1:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] e32;
        int l0;
        int l1;
    } vec_t;
    logic clk = 0, rst = 1, v = 0, fl = 0, rdy = 1;
    logic [1:0] op = 0;
    logic [63:0] a = 0, b = 0;
    logic [6:0] tag = 0, rtag;
    logic [4:0] nm = 0, rnm;
    logic [5:0] sq = 0, fsq = 0, rsq;
    int checks = 0, failures = 0, ec = 0, acc_ec = 0;
    bit got0, got1, got2;
    int lat0, lat1, lat2;
    logic [63:0] r0, r1, r2;
    vec_t tbl[8];

    always #5 clk = ~clk;
    always @(posedge clk) ec++;

    mul_if #(.XLEN(32)) i0 ();
    mul_if #(.XLEN(32)) i1 ();
    mul_if #(.XLEN(64)) i2 ();
    assign i0.valid = v;  assign i1.valid = v;  assign i2.valid = v;
    assign i0.op = mul_op_t'(op);  assign i1.op = mul_op_t'(op);  assign i2.op = mul_op_t'(op);
    assign i0.src_a = a[31:0];  assign i1.src_a = a[31:0];  assign i2.src_a = a;
    assign i0.src_b = b[31:0];  assign i1.src_b = b[31:0];  assign i2.src_b = b;
    assign i0.tag_dst = tag;  assign i1.tag_dst = tag;  assign i2.tag_dst = tag;
    assign i0.nm_dst = nm;  assign i1.nm_dst = nm;  assign i2.nm_dst = nm;
    assign i0.sqn = sq;  assign i1.sqn = sq;  assign i2.sqn = sq;
    assign i0.flush = fl;  assign i1.flush = fl;  assign i2.flush = fl;
    assign i0.flush_sqn = fsq;  assign i1.flush_sqn = fsq;  assign i2.flush_sqn = fsq;
    assign i0.res_ready = rdy;  assign i1.res_ready = rdy;  assign i2.res_ready = rdy;

    mul_iter_unit #(.XLEN(32), .BITS(4), .EARLY_TERM(0)) d0 (.clk(clk), .rst(rst), .bus(i0));
    mul_iter_unit #(.XLEN(32), .BITS(4), .EARLY_TERM(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
    mul_iter_unit #(.XLEN(64), .BITS(8), .EARLY_TERM(0)) d2 (.clk(clk), .rst(rst), .bus(i2));

    // latency is counted in edges, the accepting edge being edge 1
    always @(negedge clk) begin
        if (i0.res_valid && i0.res_ready && !got0) begin
            got0 = 1; lat0 = ec - acc_ec + 1; r0 = 64'(i0.result);
            rtag = i0.res_tag_dst; rnm = i0.res_nm_dst; rsq = i0.res_sqn;
        end
        if (i1.res_valid && i1.res_ready && !got1) begin
            got1 = 1; lat1 = ec - acc_ec + 1; r1 = 64'(i1.result);
        end
        if (i2.res_valid && i2.res_ready && !got2) begin
            got2 = 1; lat2 = ec - acc_ec + 1; r2 = i2.result;
        end
    end

    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y, input int xl);
        logic [63:0] m;
        logic signed [131:0] sx, sy, p;
        m = xl == 64 ? '1 : 64'hFFFF_FFFF;
        sx = $signed({68'd0, x & m});
        sy = $signed({68'd0, y & m});
        if (o != 2'd3 && x[xl-1]) sx = sx - (132'sd1 <<< xl);
        if (o < 2'd2 && y[xl-1]) sy = sy - (132'sd1 <<< xl);
        p = sx * sy;
        return o == 2'd0 ? p[63:0] & m : 64'(p >>> xl) & m;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [63:0] y, input int xl, input int bits, input bit et);
        logic [63:0] m, mb;
        int bl, k;
        m = xl == 64 ? '1 : 64'hFFFF_FFFF;
        mb = y & m;
        if (o < 2'd2 && mb[xl-1]) mb = (~mb + 64'd1) & m;
        if (!et) return xl / bits + 1;
        bl = 0;
        for (int i = 0; i < xl; i++) if (mb[i]) bl = i + 1;
        k = (bl + bits - 1) / bits;
        return (k < 1 ? 1 : k) + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // call at a negedge; drives one issue cycle
    task automatic start(input logic [1:0] o, input logic [63:0] va, input logic [63:0] vb);
        got0 = 0; got1 = 0; got2 = 0; lat0 = -1; lat1 = -1; lat2 = -1;
        op = o; a = va; b = vb; tag = 7'($urandom); nm = 5'($urandom);
        v = 1; acc_ec = ec + 1;
        @(negedge clk);
        v = 0;
    endtask

    task automatic wait_all();
        for (int i = 0; i < 40 && !(got0 && got1 && got2); i++) @(negedge clk);
    endtask

    task automatic run_vec(input logic [1:0] o, input logic [63:0] va, input logic [63:0] vb);
        @(negedge clk);
        sq = sq + 1;
        start(o, va, vb);
        wait_all();
        chk("d0_res", r0, ref_mul(o, va, vb, 32));
        chk("d1_res", r1, ref_mul(o, va, vb, 32));
        chk("d2_res", r2, ref_mul(o, va, vb, 64));
        chk("d0_lat", 64'(lat0), 64'(ref_lat(o, vb, 32, 4, 0)));
        chk("d1_lat", 64'(lat1), 64'(ref_lat(o, vb, 32, 4, 1)));
        chk("d2_lat", 64'(lat2), 64'(ref_lat(o, vb, 64, 8, 0)));
        chk("d0_ids", 64'({rtag, rnm, rsq}), 64'({tag, nm, sq}));
    endtask

    initial begin
        tbl[0] = '{2'd0, 64'd7, 64'hFFFF_FFFD, 32'hFFFF_FFEB, 9, 2};
        tbl[1] = '{2'd1, 64'h8000_0000, 64'h8000_0000, 32'h4000_0000, 9, 9};
        tbl[2] = '{2'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 9};
        tbl[3] = '{2'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 9};
        tbl[4] = '{2'd0, 64'd5, 64'd3, 32'd15, 9, 2};
        tbl[5] = '{2'd0, 64'd5, 64'h1000_0000, 32'h5000_0000, 9, 9};
        tbl[6] = '{2'd0, 64'd0, 64'd0, 32'd0, 9, 2};
        tbl[7] = '{2'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 32'd0, 9, 2};
        repeat (2) @(negedge clk);
        chk("rst_state", 64'({i0.busy, i0.res_valid, i0.result, i1.busy, i1.res_valid, i2.busy, i2.res_valid}), 64'd0);
        chk("rst_ids", 64'({i0.res_tag_dst, i0.res_nm_dst, i0.res_sqn}), 64'd0);
        chk("rst_res64", i2.result, 64'd0);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_d0", i), r0, 64'(tbl[i].e32));
            chk($sformatf("tbl%0d_d1", i), r1, 64'(tbl[i].e32));
            chk($sformatf("tbl%0d_lat0", i), 64'(lat0), 64'(tbl[i].l0));
            chk($sformatf("tbl%0d_lat1", i), 64'(lat1), 64'(tbl[i].l1));
        end
        run_vec(2'd3, '1, '1);
        chk("x64_mulhu", r2, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("x64_lat", 64'(lat2), 64'd9);
        for (int i = 0; i < 24; i++)
            run_vec(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom} >> $urandom_range(0, 63));
        // flush at step 3 with wrapped sqn: 0 is younger than 63
        @(negedge clk);
        sq = 0; fsq = 6'd63;
        start(2'd3, '1, '1);
        repeat (3) @(negedge clk);
        fl = 1;
        @(negedge clk);
        fl = 0;
        chk("kill_idle", 64'({i0.busy, i1.busy, i2.busy, i0.res_valid, i1.res_valid, i2.res_valid}), 64'd0);
        repeat (12) @(negedge clk);
        chk("kill_noout", 64'({got0, got1, got2}), 64'd0);
        fsq = 6'd0;
        start(2'd3, '1, '1);
        repeat (3) @(negedge clk);
        fl = 1;
        @(negedge clk);
        fl = 0;
        chk("survive_busy", 64'({i0.busy, i1.busy, i2.busy}), 64'h7);
        wait_all();
        chk("survive_res", r0, 64'hFFFF_FFFE);
        chk("survive_lat", 64'(lat0), 64'd9);
        chk("survive_res64", r2, 64'hFFFF_FFFF_FFFF_FFFE);
        // issuing uop killed in its own issue cycle is dropped
        @(negedge clk);
        fsq = 6'd63; fl = 1;
        start(2'd0, 64'd5, 64'd3);
        fl = 0;
        chk("kill_issue", 64'({i0.busy, i1.busy, i2.busy}), 64'd0);
        // backpressure hold then release
        @(negedge clk);
        rdy = 0; sq = 6'd9;
        start(2'd0, 64'd7, 64'hFFFF_FFFD);
        for (int i = 0; i < 40 && !(i0.res_valid && i1.res_valid && i2.res_valid); i++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", 64'({i0.res_valid, i0.busy, i0.result}), {30'd0, 2'b11, 32'hFFFF_FFEB});
            chk("bp_ids", 64'({i0.res_tag_dst, i0.res_nm_dst, i0.res_sqn}), 64'({tag, nm, sq}));
        end
        rdy = 1;
        @(negedge clk);
        chk("bp_release", 64'({i0.busy, i1.busy, i2.busy, i0.res_valid, i1.res_valid, i2.res_valid}), 64'd0);
        start(2'd0, 64'd5, 64'd3);
        chk("bp_reissue", 64'({i0.busy, i1.busy, i2.busy}), 64'h7);
        wait_all();
        chk("bp_next_res", r0, 64'd15);
        chk("bp_next_lat1", 64'(lat1), 64'd2);
        // reset mid-RUN abandons the uop
        @(negedge clk);
        start(2'd3, '1, '1);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid", 64'({i0.busy, i1.busy, i2.busy, i0.res_valid, i1.res_valid, i2.res_valid}), 64'd0);
        repeat (12) @(negedge clk);
        chk("rst_mid_noout", 64'({got0, got1, got2}), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
